fsquare_iter: RTL and testbench



---
 rtl/fsquare_iter.sv | 178 +++++++++++++++++
 tb/tb_fsquare_iter.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/fsquare_iter.sv
// Iterative IEEE-754 single-precision squarer: radix-4 shift-add significand
// product over 12 cycles, then one normalize/round cycle (14-cycle latency).
module fsquare_iter (
  input  logic        clk,
  input  logic        clr,
  input  logic [31:0] d,
  input  logic [1:0]  rm,
  input  logic        fsquare,
  input  logic        ena,
  output logic [31:0] s,
  output logic        busy,
  output logic        stall,
  output logic [4:0]  count,
  output logic        valid
);

  localparam logic [1:0] RM_RN     = 2'b00;
  localparam logic [1:0] RM_RU     = 2'b10;
  localparam logic [4:0] CNT_ROUND = 5'd13;

  logic [31:0] s_q, s_d;
  logic        busy_q, busy_d;
  logic [4:0]  count_q, count_d;
  logic        valid_q, valid_d;
  logic [7:0]  exp_q, exp_d;
  logic [1:0]  rm_q, rm_d;
  logic        zero_q, zero_d, den_q, den_d, inf_q, inf_d, nan_q, nan_d;
  logic [47:0] mcand_q, mcand_d;
  logic [23:0] mplr_q, mplr_d;
  logic [47:0] acc_q, acc_d;

  logic        unused_sign;
  assign unused_sign = d[31];

  logic [47:0] pp;
  always_comb begin
    case (mplr_q[1:0])
      2'd0:    pp = '0;
      2'd1:    pp = mcand_q;
      2'd2:    pp = mcand_q << 1;
      default: pp = mcand_q + (mcand_q << 1);
    endcase
  end

  logic              norm;
  logic [23:0]       sig_pre;
  logic              g_pre, r_pre, s_pre;
  logic signed [9:0] e_raw, sh_full, e_fin;
  logic [4:0]        sh_amt;
  logic [51:0]       den_shift;
  logic [25:0]       grs_vec;
  logic              sticky, inc;
  logic [24:0]       sig_sum;
  logic [31:0]       round_res;

  always_comb begin
    norm = acc_q[47];
    if (norm) begin
      sig_pre = acc_q[47:24];
      g_pre   = acc_q[23];
      r_pre   = acc_q[22];
      s_pre   = |acc_q[21:0];
    end else begin
      sig_pre = acc_q[46:23];
      g_pre   = acc_q[22];
      r_pre   = acc_q[21];
      s_pre   = |acc_q[20:0];
    end
    e_raw   = $signed({1'b0, exp_q, 1'b0}) - 10'sd127 + $signed({9'd0, norm});
    sh_full = 10'sd1 - e_raw;
    sh_amt  = 5'd0;
    // Gradual underflow: denormalize before rounding so rounding happens once.
    if (e_raw <= 10'sd0) sh_amt = (sh_full > 10'sd26) ? 5'd26 : sh_full[4:0];
    den_shift = {sig_pre, g_pre, r_pre, 26'd0} >> sh_amt;
    grs_vec   = den_shift[51:26];
    sticky    = s_pre | (|den_shift[25:0]);
    case (rm_q)
      RM_RN:   inc = grs_vec[1] & (grs_vec[0] | sticky | grs_vec[2]);
      RM_RU:   inc = grs_vec[1] | grs_vec[0] | sticky;
      default: inc = 1'b0;
    endcase
    sig_sum = {1'b0, grs_vec[25:2]} + {24'd0, inc};
    e_fin   = e_raw + $signed({9'd0, sig_sum[24]});
    if (e_raw <= 10'sd0)
      round_res = {1'b0, 7'd0, sig_sum[23], sig_sum[22:0]};
    else if (e_fin >= 10'sd255)
      round_res = (rm_q == RM_RN || rm_q == RM_RU) ? 32'h7F80_0000 : 32'h7F7F_FFFF;
    else
      round_res = {1'b0, e_fin[7:0], sig_sum[22:0]};
    if (nan_q)       round_res = 32'h7FC0_0000;
    else if (inf_q)  round_res = 32'h7F80_0000;
    else if (zero_q) round_res = 32'h0000_0000;
    else if (den_q)  round_res = (rm_q == RM_RU) ? 32'h0000_0001 : 32'h0000_0000;
  end

  always_comb begin
    s_d     = s_q;
    busy_d  = busy_q;
    count_d = count_q;
    valid_d = valid_q;
    exp_d   = exp_q;
    rm_d    = rm_q;
    zero_d  = zero_q;
    den_d   = den_q;
    inf_d   = inf_q;
    nan_d   = nan_q;
    mcand_d = mcand_q;
    mplr_d  = mplr_q;
    acc_d   = acc_q;
    if (ena) begin
      valid_d = 1'b0;
      if (!busy_q) begin
        if (fsquare) begin
          exp_d   = d[30:23];
          rm_d    = rm;
          zero_d  = (d[30:23] == 8'd0)   && (d[22:0] == 23'd0);
          den_d   = (d[30:23] == 8'd0)   && (d[22:0] != 23'd0);
          inf_d   = (d[30:23] == 8'hFF)  && (d[22:0] == 23'd0);
          nan_d   = (d[30:23] == 8'hFF)  && (d[22:0] != 23'd0);
          mcand_d = {24'd0, 1'b1, d[22:0]};
          mplr_d  = {1'b1, d[22:0]};
          acc_d   = '0;
          busy_d  = 1'b1;
          count_d = 5'd1;
        end
      end else if (count_q == CNT_ROUND) begin
        s_d     = round_res;
        valid_d = 1'b1;
        busy_d  = 1'b0;
        count_d = 5'd0;
      end else begin
        acc_d   = acc_q + pp;
        mcand_d = mcand_q << 2;
        mplr_d  = mplr_q >> 2;
        count_d = count_q + 5'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      s_q     <= '0;
      busy_q  <= 1'b0;
      count_q <= '0;
      valid_q <= 1'b0;
      exp_q   <= '0;
      rm_q    <= '0;
      zero_q  <= 1'b0;
      den_q   <= 1'b0;
      inf_q   <= 1'b0;
      nan_q   <= 1'b0;
      mcand_q <= '0;
      mplr_q  <= '0;
      acc_q   <= '0;
    end else begin
      s_q     <= s_d;
      busy_q  <= busy_d;
      count_q <= count_d;
      valid_q <= valid_d;
      exp_q   <= exp_d;
      rm_q    <= rm_d;
      zero_q  <= zero_d;
      den_q   <= den_d;
      inf_q   <= inf_d;
      nan_q   <= nan_d;
      mcand_q <= mcand_d;
      mplr_q  <= mplr_d;
      acc_q   <= acc_d;
    end
  end

  assign s     = s_q;
  assign busy  = busy_q;
  assign count = count_q;
  assign valid = valid_q;
  assign stall = (fsquare & ~busy_q) | (busy_q & (count_q != CNT_ROUND));

endmodule

// File: tb/tb_fsquare_iter.sv
// Self-checking bench for fsquare_iter: directed spec vectors, control cases,
// and randomized operands against an exact-arithmetic reference model.
module tb_fsquare_iter;

  logic        clk = 1'b0;
  logic        clr;
  logic [31:0] d;
  logic [1:0]  rm;
  logic        fsquare;
  logic        ena;
  logic [31:0] s;
  logic        busy;
  logic        stall;
  logic [4:0]  count;
  logic        valid;

  int n_checks = 0;
  int n_fail   = 0;

  fsquare_iter dut (
    .clk    (clk),
    .clr    (clr),
    .d      (d),
    .rm     (rm),
    .fsquare(fsquare),
    .ena    (ena),
    .s      (s),
    .busy   (busy),
    .stall  (stall),
    .count  (count),
    .valid  (valid)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Exact square quantized to the result ulp (subnormal ulp below 2^-126).
  function automatic logic [31:0] ref_square(input logic [31:0] x, input logic [1:0] r);
    int ex, ef, sh;
    longint unsigned frac, m, p, q, rem, half, word;
    bit up;
    ex   = int'(x[30:23]);
    frac = 64'(x[22:0]);
    if (ex == 255) return (frac != 0) ? 32'h7FC0_0000 : 32'h7F80_0000;
    if (ex == 0) begin
      if (frac == 0) return 32'h0;
      return (r == 2'b10) ? 32'h1 : 32'h0;
    end
    m  = frac | (64'd1 << 23);
    p  = m * m;
    ef = 2 * ex - 127 + (p[47] ? 1 : 0);
    if (ef < 1) ef = 1;
    sh = ef + 150 - 2 * ex;
    if (sh > 60) begin
      q    = 0;
      rem  = p;
      half = 64'h8000_0000_0000_0000;
    end else begin
      q    = p >> sh;
      rem  = p & ((64'd1 << sh) - 1);
      half = 64'd1 << (sh - 1);
    end
    case (r)
      2'b00:   up = (rem > half) || (rem == half && q[0]);
      2'b10:   up = (rem != 0);
      default: up = 1'b0;
    endcase
    q    = q + (up ? 64'd1 : 64'd0);
    word = (64'(ef - 1) << 23) + q;
    if (word >= 64'h7F80_0000) return (r == 2'b00 || r == 2'b10) ? 32'h7F80_0000 : 32'h7F7F_FFFF;
    return word[31:0];
  endfunction

  // Starts one operation at the next edge and follows it to completion.
  task automatic do_op(input logic [31:0] din, input logic [1:0] rmin, input logic [31:0] exp_s,
                       input int gap_start, input int gap_len, input bit poke);
    int  k, adv;
    bit  done;
    d = din; rm = rmin; fsquare = 1'b1; ena = 1'b1;
    #1 check_eq("stall_start", 32'(stall), 32'd1);
    @(posedge clk);
    k = 0; adv = 0; done = 1'b0;
    while (!done && k < 60) begin
      @(negedge clk);
      k++;
      fsquare = poke && (k == 5);
      d = $urandom;
      rm = 2'($urandom_range(0, 3));
      if (adv == 13) begin
        check_eq("valid_done", 32'(valid), 32'd1);
        check_eq("busy_done", 32'(busy), 32'd0);
        check_eq("count_done", 32'(count), 32'd0);
        check_eq("result", s, exp_s);
        check_eq("latency", 32'(k), 32'(14 + gap_len));
        $display("op d=%h rm=%b s=%h exp=%h latency=%0d", din, rmin, s, exp_s, k);
        done = 1'b1;
      end else begin
        check_eq("busy_run", 32'(busy), 32'd1);
        check_eq("valid_run", 32'(valid), 32'd0);
        check_eq("count_run", 32'(count), 32'(1 + adv));
        check_eq("stall_run", 32'(stall), (adv == 12) ? 32'd0 : 32'd1);
        ena = !(k >= gap_start && k < gap_start + gap_len);
        if (ena) adv++;
      end
    end
    if (!done) check_eq("timeout", 32'd0, 32'd1);
    fsquare = 1'b0;
    ena = 1'b1;
    @(negedge clk);
    check_eq("valid_pulse_end", 32'(valid), 32'd0);
  endtask

  logic [31:0] dir_d   [15];
  logic [1:0]  dir_rm  [15];
  logic [31:0] dir_exp [15];

  initial begin
    logic [31:0] rd;
    logic [1:0]  rr;
    int          sel, ex;

    dir_d   = '{32'h40400000, 32'hBF800000, 32'h80000000, 32'hFF800000, 32'h7FC00001,
                32'h3F800001, 32'h3F800001, 32'h3F800001, 32'h3F800001,
                32'h60000000, 32'h60000000, 32'h20000000, 32'h1F800000,
                32'h00000001, 32'h00000001};
    dir_rm  = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00,
                2'b00, 2'b10, 2'b11, 2'b01,
                2'b00, 2'b11, 2'b00, 2'b00,
                2'b10, 2'b00};
    dir_exp = '{32'h41100000, 32'h3F800000, 32'h00000000, 32'h7F800000, 32'h7FC00000,
                32'h3F800002, 32'h3F800003, 32'h3F800002, 32'h3F800002,
                32'h7F800000, 32'h7F7FFFFF, 32'h00800000, 32'h00200000,
                32'h00000001, 32'h00000000};

    clr = 1'b1; ena = 1'b1; fsquare = 1'b0; d = '0; rm = '0;
    repeat (2) @(negedge clk);
    check_eq("rst_s", s, 32'h0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_count", 32'(count), 32'd0);
    check_eq("rst_valid", 32'(valid), 32'd0);
    check_eq("rst_stall", 32'(stall), 32'd0);
    clr = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 15; i++) do_op(dir_d[i], dir_rm[i], dir_exp[i], 0, 0, 1'b0);

    // ena low for 3 cycles mid-run
    do_op(32'h40400000, 2'b00, 32'h41100000, 4, 3, 1'b0);
    // start request while busy must be ignored
    do_op(32'h3F800001, 2'b10, 32'h3F800003, 0, 0, 1'b1);

    // clr mid-operation
    d = 32'h40400000; rm = 2'b00; fsquare = 1'b1;
    @(posedge clk);
    @(negedge clk);
    fsquare = 1'b0;
    repeat (3) @(negedge clk);
    clr = 1'b1;
    #1;
    check_eq("clr_busy", 32'(busy), 32'd0);
    check_eq("clr_count", 32'(count), 32'd0);
    check_eq("clr_s", s, 32'h0);
    check_eq("clr_valid", 32'(valid), 32'd0);
    @(negedge clk);
    clr = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      check_eq("clr_no_valid", 32'(valid), 32'd0);
    end
    do_op(32'h40400000, 2'b00, 32'h41100000, 0, 0, 1'b0);

    for (int n = 0; n < 150; n++) begin
      sel = $urandom_range(0, 3);
      case (sel)
        0:       ex = $urandom_range(0, 255);
        1:       ex = $urandom_range(1, 70);
        2:       ex = $urandom_range(180, 200);
        default: ex = $urandom_range(100, 150);
      endcase
      rd = $urandom;
      rd[30:23] = 8'(ex);
      rr = 2'($urandom_range(0, 3));
      do_op(rd, rr, ref_square(rd, rr), 0, 0, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
